// File: rtl/aes_sched_pkg.sv
// Shared types and helpers for the AES core scheduler.
package aes_sched_pkg;

  // Scheduler FSM encoding
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    START   = 3'd2,
    WAIT_LO = 3'd3,
    WAIT_HI = 3'd4,
    RESP    = 3'd5
  } sched_state_e;

  localparam logic AES_128_BIT_KEY = 1'b0;
  localparam logic AES_256_BIT_KEY = 1'b1;

  // Ceiling log2 for elaboration-time widths (returns 0 for n <= 1)
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/aes_rr_arbiter.sv
// Round-robin winner pick: first asserted request at or after rr_ptr,
// wrapping from NUM_REQ-1 back to 0. Purely combinational.
module aes_rr_arbiter
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [ID_W-1:0]    win_id,
  output logic               win_valid
);

  // Requests rotated so bit k is requester (rr_ptr + k) mod NUM_REQ
  logic [NUM_REQ-1:0] rot;
  assign rot = NUM_REQ'({req_valid, req_valid} >> rr_ptr);

  // Scan from the far end so the lowest rotated offset wins last
  always_comb begin
    int idx;
    idx       = 0;
    win_id    = '0;
    win_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        win_id    = ID_W'(idx);
        win_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aes_core_scheduler.sv
// Shares one AES encipher core between NUM_REQ requesters. One operation at a
// time: arbitrate, latch block/keylen, pulse core_next, wait out the core busy
// window, return the result tagged with the requester ID.
// Optional watchdog: define AES_SCHED_TIMEOUT_EN to bound the core wait and
// return an error response (rsp_error=1, rsp_block=0) after TIMEOUT_CYCLES.
module aes_core_scheduler
  import aes_sched_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ID_W           = clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   cfg_keylen,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ*128-1:0] req_block,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [ID_W-1:0]        rsp_id,
  output logic [127:0]           rsp_block,
  output logic                   rsp_error,
  output logic                   core_next,
  output logic                   core_keylen,
  output logic [127:0]           core_block,
  input  logic                   core_ready,
  input  logic [127:0]           core_result,
  output logic                   busy
);

  sched_state_e              state, state_nxt;
  logic [NUM_REQ-1:0][127:0] blk_arr;
  logic [ID_W-1:0]           rr_ptr, win_id, grant_id;
  logic                      win_valid;
  logic                      wd_to;
  logic                      in_wait;

  assign blk_arr = req_block;
  assign in_wait = (state == WAIT_LO) || (state == WAIT_HI);

  aes_rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req_valid (req_valid),
    .rr_ptr    (rr_ptr),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

`ifdef AES_SCHED_TIMEOUT_EN
  localparam int WD_W = clog2(TIMEOUT_CYCLES) + 1;
  logic [WD_W-1:0] wd_cnt;
  logic            err_q;

  // Wait-cycle counter: cleared on the start pulse, runs while waiting on the core
  always_ff @(posedge clk) begin
    if (reset)                 wd_cnt <= '0;
    else if (state == START)   wd_cnt <= '0;
    else if (in_wait)          wd_cnt <= wd_cnt + 1'b1;
  end

  // Normal completion in WAIT_HI takes priority over a same-cycle expiry
  assign wd_to = in_wait && (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) &&
                 !((state == WAIT_HI) && core_ready);

  // Error flag for the response in flight; cleared at each new grant
  always_ff @(posedge clk) begin
    if (reset)               err_q <= 1'b0;
    else if (state == GRANT) err_q <= 1'b0;
    else if (wd_to)          err_q <= 1'b1;
  end

  assign rsp_error = err_q && (state == RESP);
`else
  // Keeps TIMEOUT_CYCLES referenced when the watchdog is compiled out
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign wd_to          = 1'b0;
  assign rsp_error      = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (core_ready && win_valid) state_nxt = GRANT;
      GRANT:   state_nxt = START;
      START:   state_nxt = WAIT_LO;
      WAIT_LO: if (wd_to) state_nxt = RESP;
               else if (!core_ready) state_nxt = WAIT_HI;
      WAIT_HI: if (core_ready || wd_to) state_nxt = RESP;
      RESP:    if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant pulse to the winner chosen in IDLE
  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = 1'b1;
  end

  assign core_next = (state == START);
  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);

  // Operation latches: winner, request data, pointer advance, result capture
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id    <= '0;
      rr_ptr      <= '0;
      core_block  <= '0;
      core_keylen <= AES_128_BIT_KEY;
      rsp_id      <= '0;
      rsp_block   <= '0;
    end else begin
      if ((state == IDLE) && core_ready && win_valid) grant_id <= win_id;
      if (state == GRANT) begin
        core_block  <= blk_arr[grant_id];
        core_keylen <= cfg_keylen;
        rsp_id      <= grant_id;
        rr_ptr      <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if ((state == WAIT_HI) && core_ready) rsp_block <= core_result;
      else if (wd_to)                       rsp_block <= '0;
    end
  end

endmodule

// File: tb/tb_aes_core_scheduler.sv
// Bench for aes_core_scheduler: behavioural core model, round-robin scoreboard
// monitor, a directed vector table and hand-written corner sequences.
`timescale 1ns/1ps
module tb_aes_core_scheduler;
  import aes_sched_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int TO  = 64;
  localparam logic [127:0] PT    = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT128 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT256 = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] K128  = {16{8'ha5}};
  localparam logic [127:0] K256  = {16{8'h3c}};

  logic             clk = 1'b0;
  logic             reset, cfg_keylen, rsp_ready, core_ready;
  logic [N-1:0]     req_valid, req_ready;
  logic [N*128-1:0] req_block;
  logic             rsp_valid, rsp_error, core_next, core_keylen, busy;
  logic [IDW-1:0]   rsp_id;
  logic [127:0]     rsp_block, core_block, core_result;

  always #5 clk = ~clk;

  aes_core_scheduler #(.NUM_REQ(N), .ID_W(IDW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset), .cfg_keylen(cfg_keylen),
    .req_valid(req_valid), .req_block(req_block), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_block(rsp_block), .rsp_error(rsp_error),
    .core_next(core_next), .core_keylen(core_keylen), .core_block(core_block),
    .core_ready(core_ready), .core_result(core_result), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  // Stand-in cipher: FIPS-197 C.1/C.3 answers for their plaintext, else a keyed swap
  function automatic logic [127:0] aes_ref(input logic [127:0] b, input logic k);
    if (b == PT) return k ? CT256 : CT128;
    return {b[63:0], b[127:64]} ^ (k ? K256 : K128);
  endfunction

  // ---------------- core model ----------------
  int           lat_min = 0, lat_max = 6;
  bit           core_hang = 1'b0;
  int           core_cnt;
  logic [127:0] core_pend;

  always @(posedge clk) begin
    if (reset) begin
      core_ready  <= 1'b1;
      core_result <= '0;
      core_cnt    <= 0;
    end else if (core_next) begin
      core_ready  <= 1'b0;
      core_cnt    <= $urandom_range(lat_max, lat_min);
      core_pend   <= aes_ref(core_block, core_keylen);
      core_result <= {$urandom, $urandom, $urandom, $urandom};
    end else if (!core_ready && !core_hang) begin
      if (core_cnt == 0) begin
        core_ready  <= 1'b1;
        core_result <= core_pend;
      end else core_cnt <= core_cnt - 1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  typedef struct { int id; logic [127:0] blk; } rsp_t;
  rsp_t         rsp_q[$];
  int           grant_log[$];
  logic [N-1:0] accepted = '0;
  logic [N-1:0] prev_rv = '0, prev_rr = '0;
  bit           mon_en = 1'b1;
  int           cyc = 0, ptr_m = 0, exp_gid = 0, rsp_seen = 0;
  int           grant_due, next_due, rsp_due;
  bit           wait_grant, wait_next, wait_rise, due_chk, prev_cr;
  logic [127:0] exp_blk;
  logic         exp_key;

  initial forever begin
    @(negedge clk);
    cyc++;
    accepted |= req_ready;
    if (reset) begin
      wait_grant = 0; wait_next = 0; wait_rise = 0; due_chk = 0;
      ptr_m = 0; rsp_q.delete(); prev_rv = '0; prev_rr = '0;
    end else if (mon_en) begin
      assert (!(|(prev_rv & ~prev_rr & ~req_valid)))
        else $error("requester withdrew before acceptance");
      if (req_ready != '0) begin
        chk("grant_expected", wait_grant, 1);
        chk("grant_onehot", req_ready, N'(1) << exp_gid);
        chk("grant_latency", cyc, grant_due);
        grant_log.push_back(exp_gid);
        ptr_m     = (exp_gid + 1) % N;
        exp_blk   = req_block[exp_gid*128 +: 128];
        exp_key   = cfg_keylen;
        wait_grant = 0; wait_next = 1; next_due = cyc + 1;
      end else if (wait_grant && cyc > grant_due) begin
        chk("grant_missing", 0, 1); wait_grant = 0;
      end
      if (core_next) begin
        chk("next_expected", wait_next, 1);
        chk("next_latency", cyc, next_due);
        chk("core_block", core_block, exp_blk);
        chk("core_keylen", core_keylen, exp_key);
        rsp_q.push_back('{exp_gid, aes_ref(exp_blk, exp_key)});
        wait_next = 0; wait_rise = 1;
      end else if (wait_next && cyc > next_due) begin
        chk("next_missing", 0, 1); wait_next = 0;
      end
      if (due_chk && cyc == rsp_due) begin
        chk("rsp_latency", rsp_valid, 1); due_chk = 0;
      end
      if (wait_rise && core_ready && !prev_cr) begin
        rsp_due = cyc + 1; due_chk = 1; wait_rise = 0;
      end
      if (rsp_valid && rsp_ready) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          rsp_t r;
          r = rsp_q.pop_front();
          chk("rsp_id", rsp_id, r.id);
          chk("rsp_block", rsp_block, r.blk);
          chk("rsp_error", rsp_error, 0);
          rsp_seen++;
        end
      end
      // Round-robin decision taken in IDLE, from the spec rule
      if (!busy && core_ready && |req_valid && !wait_grant) begin
        int w;
        w = -1;
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr_m + k) % N;
          if (w < 0 && req_valid[j]) w = j;
        end
        exp_gid = w; grant_due = cyc + 1; wait_grant = 1;
      end
      prev_rv = req_valid; prev_rr = req_ready;
    end
    prev_cr = core_ready;
  end

  // ---------------- stimulus helpers ----------------
  int issued = 0;

  task automatic tick();
    @(posedge clk); #1;
    req_valid = req_valid & ~accepted;
    accepted  = '0;
  endtask

  task automatic req(input int id, input logic [127:0] b);
    req_valid[id] = 1'b1;
    req_block[id*128 +: 128] = b;
    issued++;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; req_block = '0; rsp_ready = 1'b1; cfg_keylen = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic check_zero(input string p);
    chk({p, "_req_ready"},   req_ready,   0);
    chk({p, "_rsp_valid"},   rsp_valid,   0);
    chk({p, "_rsp_id"},      rsp_id,      0);
    chk({p, "_rsp_block"},   rsp_block,   0);
    chk({p, "_rsp_error"},   rsp_error,   0);
    chk({p, "_core_next"},   core_next,   0);
    chk({p, "_core_keylen"}, core_keylen, 0);
    chk({p, "_core_block"},  core_block,  0);
    chk({p, "_busy"},        busy,        0);
  endtask

  task automatic wait_hs(input int lim, output logic [IDW-1:0] id, output logic [127:0] blk);
    bit ok;
    ok = 0; id = '0; blk = '0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin ok = 1; id = rsp_id; blk = rsp_block; end
      tick();
      if (ok) break;
    end
    if (!ok) chk("rsp_wait_timeout", 0, 1);
  endtask

  task automatic wait_next_pulse(input int lim);
    bit ok;
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (core_next) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("core_next_wait_timeout", 0, 1);
  endtask

  typedef struct {
    int id; logic key; logic [127:0] blk;
    logic [IDW-1:0] exp_id; logic [127:0] exp_blk;
  } vec_t;

  initial begin
    vec_t           tbl[4];
    logic [IDW-1:0] id;
    logic [127:0]   blk, held;
    int             seen;

    global_guard();
    tbl[0] = '{2, 1'b0, PT, 2'd2, CT128};
    tbl[1] = '{1, 1'b1, PT, 2'd1, CT256};
    tbl[2] = '{0, 1'b0, 128'h0, 2'd0, K128};
    tbl[3] = '{3, 1'b1, 128'h0000000000000001_0000000000000000, 2'd3,
               128'h3c3c3c3c3c3c3c3c3c3c3c3c3c3c3c3d};

    req_valid = '0; req_block = '0; rsp_ready = 1'b1; cfg_keylen = 1'b0; reset = 1'b1;
    do_reset();
    @(negedge clk);
    check_zero("reset");
    tick();

    // Directed table, one request at a time
    foreach (tbl[i]) begin
      cfg_keylen = tbl[i].key;
      req(tbl[i].id, tbl[i].blk);
      wait_hs(100, id, blk);
      chk($sformatf("tbl%0d_id", i), id, tbl[i].exp_id);
      chk($sformatf("tbl%0d_blk", i), blk, tbl[i].exp_blk);
    end

    // Round-robin order from pointer 0
    do_reset();
    grant_log.delete();
    for (int i = 0; i < N; i++) req(i, {96'h0, 32'(i + 16)});
    for (int i = 0; i < N; i++) wait_hs(100, id, blk);
    req(1, 128'h11); req(3, 128'h33);
    for (int i = 0; i < 2; i++) wait_hs(100, id, blk);
    chk("rr_log_size", grant_log.size(), 6);
    for (int i = 0; i < N; i++) chk($sformatf("rr_order%0d", i), grant_log[i], i);
    chk("rr_order4", grant_log[4], 1);
    chk("rr_order5", grant_log[5], 3);

    // Backpressure: response held, no grant or start pulse while stalled
    rsp_ready = 1'b0;
    req(0, 128'hdead_beef); req(1, 128'hcafe);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (rsp_valid) break;
      tick();
    end
    held = rsp_block;
    chk("stall_blk", held, aes_ref(128'hdead_beef, cfg_keylen));
    for (int i = 0; i < 20; i++) begin
      tick();
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_hold", rsp_block, held);
      chk("stall_no_grant", req_ready, 0);
      chk("stall_no_next", core_next, 0);
    end
    tick();
    rsp_ready = 1'b1;
    wait_hs(10, id, blk);
    chk("stall_rsp_id", id, 0);
    wait_hs(100, id, blk);
    chk("stall_rsp2_id", id, 1);

    // keylen latched at grant; toggling afterwards is ignored
    cfg_keylen = 1'b1;
    req(2, PT);
    seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) begin seen = 1; blk = rsp_block; end
      tick();
      if (!req_valid[2]) cfg_keylen = ~cfg_keylen;
      if (seen) break;
    end
    chk("keylen_seen", seen, 1);
    chk("keylen_c3", blk, CT256);
    chk("keylen_hold", core_keylen, 1);

    // Reset while waiting for the core to finish
    lat_min = 10; lat_max = 10;
    cfg_keylen = 1'b1;
    req(3, PT);
    wait_next_pulse(20);
    for (int i = 0; i < 4; i++) tick();
    reset = 1'b1; req_valid = '0;
    tick();
    @(negedge clk);
    check_zero("midrst");
    tick();
    reset = 1'b0; cfg_keylen = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rsp_valid) seen++;
      tick();
    end
    chk("midrst_no_rsp", seen, 0);
    lat_min = 0; lat_max = 6;
    req(1, PT);
    wait_hs(100, id, blk);
    chk("midrst_after_id", id, 1);
    chk("midrst_after_blk", blk, CT128);

`ifdef AES_SCHED_TIMEOUT_EN
    // Watchdog: core never completes
    do_reset();
    mon_en = 1'b0; core_hang = 1'b1;
    req(0, PT);
    wait_next_pulse(20);
    seen = 0;
    for (int k = 1; k <= 4 * TO; k++) begin
      tick();
      @(negedge clk);
      if (rsp_valid) begin seen = k; break; end
    end
    chk("to_latency", seen, TO + 1);
    chk("to_error", rsp_error, 1);
    chk("to_block", rsp_block, 0);
    chk("to_id", rsp_id, 0);
    tick();
    @(negedge clk);
    chk("to_rsp_done", rsp_valid, 0);
    core_hang = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    mon_en = 1'b1;
`endif

    // Randomized traffic against the scoreboard
    do_reset();
    issued = 0; rsp_seen = 0;
    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < N; i++)
        if (!req_valid[i] && $urandom_range(3, 0) == 0) req(i, {$urandom, $urandom, $urandom, $urandom});
      rsp_ready  = ($urandom_range(3, 0) != 0);
      cfg_keylen = 1'($urandom);
      tick();
    end
    rsp_ready = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if (req_valid == '0 && !busy && rsp_q.size() == 0) break;
      tick();
    end
    chk("drain_idle", {req_valid, busy}, 0);
    chk("rsp_count", rsp_seen, issued);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic global_guard();
    fork
      begin
        #2_000_000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench time limit");
      end
    join_none
  endtask

endmodule
